// File: rtl/spi_master.sv
// SPI master for the 10-bit-frame slave: serialises host commands and captures read-data bytes.
// Optional abort input is compiled in with `define SPI_MASTER_ABORT_EN.
module spi_master #(
    parameter int unsigned READ_WAIT = 2,
    parameter int unsigned GAP       = 2
) (
    input  logic       clk,
    input  logic       rst,
`ifdef SPI_MASTER_ABORT_EN
    input  logic       abort,
`endif
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [9:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
);

    localparam int unsigned WaitW = (READ_WAIT > 1) ? $clog2(READ_WAIT + 1) : 1;
    localparam int unsigned GapW  = (GAP > 1) ? $clog2(GAP + 1) : 1;

    typedef enum logic [2:0] {StIdle, StStart, StShift, StWait, StRead, StEnd} state_e;

    state_e           state_q, state_d;
    logic [9:0]       frame_q, frame_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
    logic [2:0]       rd_cnt_q, rd_cnt_d;
    logic [GapW-1:0]  gap_cnt_q, gap_cnt_d;
    logic [7:0]       rx_q, rx_d;
    logic [7:0]       rsp_data_q, rsp_data_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             ss_n_q, ss_n_d;
    logic             mosi_q, mosi_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             busy_q, busy_d;
    logic             abort_req;

`ifdef SPI_MASTER_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            frame_q     <= '0;
            bit_cnt_q   <= '0;
            wait_cnt_q  <= '0;
            rd_cnt_q    <= '0;
            gap_cnt_q   <= '0;
            rx_q        <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            ss_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_q     <= frame_d;
            bit_cnt_q   <= bit_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            rx_q        <= rx_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
            ss_n_q      <= ss_n_d;
            mosi_q      <= mosi_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        frame_d     = frame_q;
        bit_cnt_d   = bit_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        rx_d        = rx_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid && cmd_ready_q) begin
                    frame_d = cmd_data;
                    state_d = StStart;
                end
            end
            StStart: begin
                bit_cnt_d = 4'd11;
                state_d   = StShift;
            end
            StShift: begin
                if (bit_cnt_q == 4'd0) begin
                    if (frame_q[9:8] == 2'b11) begin
                        if (READ_WAIT == 0) begin
                            rd_cnt_d = 3'd7;
                            state_d  = StRead;
                        end else begin
                            wait_cnt_d = WaitW'(READ_WAIT);
                            state_d    = StWait;
                        end
                    end else begin
                        gap_cnt_d = GapW'(GAP);
                        state_d   = StEnd;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q - 4'd1;
                end
            end
            StWait: begin
                if (wait_cnt_q == WaitW'(1)) begin
                    rd_cnt_d = 3'd7;
                    state_d  = StRead;
                end else begin
                    wait_cnt_d = wait_cnt_q - WaitW'(1);
                end
            end
            StRead: begin
                rx_d = {rx_q[6:0], MISO};
                if (rd_cnt_q == 3'd0) begin
                    rsp_data_d  = rx_d;
                    rsp_valid_d = 1'b1;
                    gap_cnt_d   = GapW'(GAP);
                    state_d     = StEnd;
                end else begin
                    rd_cnt_d = rd_cnt_q - 3'd1;
                end
            end
            StEnd: begin
                if (gap_cnt_q == GapW'(1)) begin
                    state_d = StIdle;
                end else begin
                    gap_cnt_d = gap_cnt_q - GapW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
        // Abort wins over a completing read so the response is suppressed.
        if (abort_req && (state_q inside {StStart, StShift, StWait, StRead})) begin
            state_d     = StEnd;
            gap_cnt_d   = GapW'(GAP);
            rsp_valid_d = 1'b0;
            rsp_data_d  = rsp_data_q;
            rx_d        = rx_q;
        end
    end

    // Outputs are decoded from the next state so the registered pins line up with state_q.
    always_comb begin
        ss_n_d      = 1'b1;
        mosi_d      = 1'b0;
        cmd_ready_d = (state_d == StIdle);
        busy_d      = (state_d != StIdle);
        unique case (state_d)
            StStart: begin
                ss_n_d = 1'b0;
                mosi_d = frame_d[9];
            end
            StShift: begin
                ss_n_d = 1'b0;
                mosi_d = (bit_cnt_d >= 4'd10) ? frame_d[9] : frame_d[bit_cnt_d];
            end
            StWait, StRead: ss_n_d = 1'b0;
            default: ss_n_d = 1'b1;
        endcase
    end

    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign SS_n      = ss_n_q;
    assign MOSI      = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed self-checking bench for spi_master (READ_WAIT=2, GAP=2).
// Define SPI_MASTER_ABORT_EN to also exercise the abort input.
module tb_spi_master;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [9:0] cmd_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       busy;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
`ifdef SPI_MASTER_ABORT_EN
    logic       abort;
`endif

    int n_cmp = 0;
    int n_err = 0;

    spi_master #(
        .READ_WAIT(2),
        .GAP(2)
    ) dut (
        .clk(clk),
        .rst(rst),
`ifdef SPI_MASTER_ABORT_EN
        .abort(abort),
`endif
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_data(cmd_data),
        .rsp_valid(rsp_valid),
        .rsp_data(rsp_data),
        .busy(busy),
        .SS_n(SS_n),
        .MOSI(MOSI),
        .MISO(MISO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 60 && cmd_ready !== 1'b1; i++) @(negedge clk);
        check("ready_wait", 32'(cmd_ready), 32'h1);
    endtask

    // Issue one frame and watch the SS_n-low window; MISO carries miso_byte during READ cycles.
    task automatic run_frame(input logic [9:0] d, input logic [7:0] miso_byte,
                             output int low, output logic [12:0] mseq, output bit rsp_early);
        wait_ready();
        cmd_data  = d;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        low       = 0;
        mseq      = '0;
        rsp_early = 1'b0;
        while (SS_n === 1'b0 && low < 40) begin
            mseq = {mseq[11:0], MOSI};
            if (rsp_valid === 1'b1) rsp_early = 1'b1;
            MISO = (low >= 15 && low <= 22) ? miso_byte[22 - low] : 1'b0;
            low++;
            @(negedge clk);
        end
        MISO = 1'b0;
    endtask

    int          low;
    logic [12:0] mseq;
    bit          rsp_early;
    int          t;
    int          acc0;
    int          acc1;
    int          high_run;
    int          gap_seen;
    bit          fire;
    bit          prev_ss;
    bit          stray;

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_data  = '0;
        MISO      = 1'b0;
`ifdef SPI_MASTER_ABORT_EN
        abort     = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_ss_n", 32'(SS_n), 32'h1);
        check("rst_mosi", 32'(MOSI), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_data", 32'(rsp_data), 32'h00);
        check("rst_cmd_ready", 32'(cmd_ready), 32'h1);
        check("rst_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Write frame 0x0A5: 13-cycle window, MOSI 0,0,0,0,0,1,0,1,0,0,1,0,1.
        run_frame(10'h0A5, 8'h00, low, mseq, rsp_early);
        check("wr_low_len", 32'(low), 32'd13);
        check("wr_mosi_seq", 32'(mseq), 32'h00A5);
        check("wr_no_rsp", 32'(rsp_early), 32'h0);
        check("wr_end1_ready", 32'(cmd_ready), 32'h0);
        check("wr_end1_busy", 32'(busy), 32'h1);
        check("wr_end1_rsp", 32'(rsp_valid), 32'h0);
        @(negedge clk);
        check("wr_end2_ss_n", 32'(SS_n), 32'h1);
        check("wr_end2_ready", 32'(cmd_ready), 32'h0);
        @(negedge clk);
        check("wr_idle_ready", 32'(cmd_ready), 32'h1);
        check("wr_idle_busy", 32'(busy), 32'h0);
        check("wr_idle_mosi", 32'(MOSI), 32'h0);

        // Read-data frame 0x300 returning 0x5C: 13 + 2 + 8 = 23 cycles low.
        run_frame(10'h300, 8'h5C, low, mseq, rsp_early);
        check("rd_low_len", 32'(low), 32'd23);
        check("rd_no_early_rsp", 32'(rsp_early), 32'h0);
        check("rd_rsp_valid", 32'(rsp_valid), 32'h1);
        check("rd_rsp_data", 32'(rsp_data), 32'h5C);
        @(negedge clk);
        check("rd_rsp_strobe_end", 32'(rsp_valid), 32'h0);
        check("rd_rsp_hold", 32'(rsp_data), 32'h5C);

        // Back-to-back: accept period 16, 3 high cycles (END x2 + IDLE) between windows.
        wait_ready();
        cmd_data  = 10'h10F;
        cmd_valid = 1'b1;
        t         = 0;
        acc0      = -1;
        acc1      = -1;
        high_run  = 0;
        gap_seen  = -1;
        prev_ss   = 1'b1;
        for (int i = 0; i < 45; i++) begin
            fire = (cmd_ready === 1'b1) && cmd_valid;
            @(negedge clk);
            t++;
            if (fire) begin
                if (acc0 < 0) begin
                    acc0     = t;
                    cmd_data = 10'h2F0;
                end else if (acc1 < 0) begin
                    acc1      = t;
                    cmd_valid = 1'b0;
                end
            end
            if (SS_n === 1'b0) begin
                if (prev_ss && acc1 >= 0 && gap_seen < 0) gap_seen = high_run;
                high_run = 0;
            end else begin
                high_run++;
            end
            prev_ss = SS_n;
        end
        cmd_valid = 1'b0;
        check("b2b_first_accept", 32'(acc0), 32'd1);
        check("b2b_period", 32'(acc1 - acc0), 32'd16);
        check("b2b_gap", 32'(gap_seen), 32'd3);

        // Reset during the 6th SHIFT cycle of a read frame.
        wait_ready();
        cmd_data  = 10'h3AA;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (6) @(negedge clk);
        check("mid_shift_ss_low", 32'(SS_n), 32'h0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_ss_n", 32'(SS_n), 32'h1);
        check("mid_rst_ready", 32'(cmd_ready), 32'h1);
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_rsp_data", 32'(rsp_data), 32'h00);
        stray = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || SS_n !== 1'b1) stray = 1'b1;
        end
        check("mid_rst_quiet", 32'(stray), 32'h0);

        run_frame(10'h3C3, 8'hA6, low, mseq, rsp_early);
        check("post_rst_low_len", 32'(low), 32'd23);
        check("post_rst_rsp_valid", 32'(rsp_valid), 32'h1);
        check("post_rst_rsp_data", 32'(rsp_data), 32'hA6);

`ifdef SPI_MASTER_ABORT_EN
        // Abort in the 3rd READ cycle (cycle 17 of the window).
        wait_ready();
        cmd_data  = 10'h3FF;
        cmd_valid = 1'b1;
        MISO      = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (17) @(negedge clk);
        check("ab_pre_ss_low", 32'(SS_n), 32'h0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        MISO  = 1'b0;
        check("ab_ss_n", 32'(SS_n), 32'h1);
        check("ab_rsp_valid", 32'(rsp_valid), 32'h0);
        check("ab_ready_in_gap", 32'(cmd_ready), 32'h0);
        stray = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) stray = 1'b1;
        end
        check("ab_no_rsp", 32'(stray), 32'h0);
        check("ab_ready_after_gap", 32'(cmd_ready), 32'h1);
        check("ab_rsp_data_kept", 32'(rsp_data), 32'hA6);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- SPI master (initiator) for the team's 10-bit-frame SPI slave.
- Accepts 10-bit command words from a host-side valid/ready interface and drives SS_n and MOSI with the slave's framing.
- For read-data commands (opcode bits [9:8] = 2'b11), samples 8 MISO bits and returns them on a one-cycle response strobe.
- Sits between the system controller and the SPI pins, in the same clock domain as the slave (no SCLK; slave samples on clk).

Parameters:
- READ_WAIT, 2, idle cycles after the last MOSI bit of a read-data frame before MISO sampling starts (covers slave memory latency).
- GAP, 2, minimum clk cycles SS_n stays high between frames (≥1).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  host presents a frame.
- cmd_ready  output  1  master can accept a frame (high only in IDLE).
- cmd_data  input  10  frame: [9:8] opcode, [7:0] address/data.
- rsp_valid  output  1  one-cycle strobe: rsp_data valid.
- rsp_data  output  8  byte read from the slave, MSB first on MISO.
- busy  output  1  high in any state other than IDLE.
- SS_n  output  1  slave select, active low.
- MOSI  output  1  serial data to the slave.
- MISO  input  1  serial data from the slave.

Behaviour:
- Reset (clk edge with rst=1, from any state, including mid-frame): state IDLE; SS_n=1, MOSI=0, rsp_valid=0, rsp_data=8'h00, busy=0, cmd_ready=1. All counters are cleared and the frame register is set to 0. No response is produced for an interrupted frame.
- States: IDLE, START, SHIFT, WAIT, READ, END. All outputs are registered.
- IDLE:
  - SS_n=1, MOSI=0, cmd_ready=1.
  - On cmd_valid&&cmd_ready: latch cmd_data into frame_q, then go to START.
  - cmd_valid is ignored in every other state.
- START (1 cycle): SS_n=0, MOSI=frame_q[9]. This lets the slave leave its idle state. Next state is SHIFT with bit_cnt=11.
- SHIFT (12 cycles, bit_cnt 11→0): SS_n=0.
  - MOSI=frame_q[9] while bit_cnt≥10, otherwise MOSI=frame_q[bit_cnt].
  - The first cycle is the slave's command-decode cycle, the second is its dummy shift slot, and the remaining ten carry bits 9..0.
  - At bit_cnt=0: go to WAIT (with wait_cnt=READ_WAIT) if frame_q[9:8]==2'b11, otherwise go to END.
- WAIT (READ_WAIT cycles): SS_n=0, MOSI=0. Then go to READ with rd_cnt=7. If READ_WAIT=0, go straight from SHIFT to READ.
- READ (8 cycles): SS_n=0, MOSI=0.
  - Each cycle shifts MISO into rx_q: rx_q <= {rx_q[6:0], MISO}.
  - After the 8th sample, on the same edge: rsp_data <= final shifted value, rsp_valid <= 1 for exactly one cycle, then go to END.
- END (GAP cycles): SS_n=1, MOSI=0. Then go to IDLE.
- Frame lengths, with SS_n low from START through the last SHIFT/READ cycle:
  - Non-read frame: 13 cycles.
  - Read-data frame: 13+READ_WAIT+8 cycles.
- Back-to-back commands:
  - Accept-to-accept period is 13+GAP+1 cycles for non-read frames.
  - A command held valid during a frame is accepted on the first IDLE cycle.
- Opcode semantics (write, read-address, read-data) belong to the slave. The master treats only 2'b11 specially.
- rsp_data holds its value until the next read response or reset.

Optional Feature:
- Macro: SPI_MASTER_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort=1 in START, SHIFT, WAIT or READ: next state is END, SS_n=1 on the next cycle, and the GAP is honoured.
  - No rsp_valid is produced for the aborted frame. Partial rx_q is discarded and rsp_data is unchanged.
  - abort is ignored in IDLE and END.
- Undefined: no abort port; every accepted frame runs to completion.

Test Plan:
- Reset held 3 cycles → SS_n=1, MOSI=0, rsp_valid=0, rsp_data=8'h00, cmd_ready=1, busy=0.
- Write frame cmd_data=10'h0A5 → SS_n low exactly 13 cycles; MOSI sequence 0,0,0,0,0,1,0,1,0,0,1,0,1; no rsp_valid; SS_n high ≥2 cycles; cmd_ready returns.
- Read-data frame cmd_data=10'h300, MISO model drives 8'h5C MSB-first during READ → rsp_valid one cycle, rsp_data=8'h5C; SS_n low 23 cycles (READ_WAIT=2).
- Back-to-back: cmd_valid held high with 10'h10F then 10'h2F0 → second accepted exactly 16 cycles after first; no overlap of SS_n-low periods.
- rst asserted in the 6th SHIFT cycle of a read frame → next cycle SS_n=1, state IDLE, no rsp_valid; the next frame runs normally.
- With SPI_MASTER_ABORT_EN: abort pulsed during READ of frame 10'h3FF → SS_n=1 next cycle, no rsp_valid, rsp_data keeps its previous value, cmd_ready high after GAP.
